// File: rtl/ram_ctrl.sv
`timescale 1ns/1ps
// ram_ctrl -- single-port word RAM behind a valid/ready request channel and a
// valid/ready read-response channel, with an optional zeroing sweep after reset.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  request present
//   req_ready  request accepted this cycle when req_valid is also high
//   req_write  1 = write, 0 = read
//   req_addr   word address (addresses >= DEPTH are out of range)
//   req_wdata  write data
//   req_be     byte write enables, one per byte of req_wdata
//   rsp_valid  read response present
//   rsp_ready  consumer accepts the response
//   rsp_data   read data (zero for out-of-range reads)
//   rsp_err    response address was out of range
//   busy       zeroing sweep in progress
module ram_ctrl #(
  parameter int WIDTH          = 32,
  parameter int DEPTH          = 256,
  parameter int AW             = $clog2(DEPTH),
  parameter int LAT            = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [AW-1:0]      req_addr,
  input  logic [WIDTH-1:0]   req_wdata,
  input  logic [WIDTH/8-1:0] req_be,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_data,
  output logic               rsp_err,
  output logic               busy
);

  localparam int NB = WIDTH / 8;
  // One extra bit so that DEPTH itself is representable when DEPTH == 2**AW.
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST_C  = AW'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

  // Memory words are deliberately left without a reset; only the sweep zeroes them.
  logic [WIDTH-1:0] mem_r [DEPTH];

  state_t           state_r, state_s;
  logic [AW-1:0]    cnt_r, cnt_s;

  logic             rsp_valid_r;
  logic [WIDTH-1:0] rsp_data_r;
  logic             rsp_err_r;

  logic             out_free_s;
  logic             stall_s;
  logic             in_range_s;
  logic [WIDTH-1:0] rd_word_s;
  logic             accept_s;
  logic             rd_accept_s;
  logic             wr_accept_s;

  // State and sweep-counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= RST_STATE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state logic: sweep every address once, then run forever.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_CLEAR: begin
        if (cnt_r == LAST_C) begin
          state_s = ST_RUN;
          cnt_s   = '0;
        end else begin
          cnt_s = cnt_r + AW'(1);
        end
      end
      ST_RUN: begin
        state_s = ST_RUN;
      end
      default: begin
        state_s = RST_STATE;
        cnt_s   = '0;
      end
    endcase
  end

  // The output register can take a new value when empty or being drained now.
  assign out_free_s = !rsp_valid_r || rsp_ready;

  // Request handshake and address decode; the word is captured at acceptance.
  always_comb begin
    in_range_s = ({1'b0, req_addr} < DEPTH_C);
    if (in_range_s) begin
      rd_word_s = mem_r[req_addr];
    end else begin
      rd_word_s = '0;
    end
    req_ready   = rst_n && (state_r == ST_RUN) && !stall_s;
    accept_s    = req_valid && req_ready;
    rd_accept_s = accept_s && !req_write;
    wr_accept_s = accept_s && req_write && in_range_s;
  end

  // Memory array: sweep writes zero, accepted in-range writes merge by byte.
  always_ff @(posedge clk) begin
    if (rst_n && (state_r == ST_CLEAR)) begin
      mem_r[cnt_r] <= '0;
    end else if (wr_accept_s) begin
      for (int i = 0; i < NB; i++) begin
        if (req_be[i]) begin
          mem_r[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

  generate
    if (LAT == 2) begin : g_lat2
      logic             s1_valid_r;
      logic [WIDTH-1:0] s1_data_r;
      logic             s1_err_r;

      // With a stalled output, an empty first stage can still absorb one read.
      assign stall_s = !out_free_s && s1_valid_r;

      // Two-stage read pipeline: first stage feeds the output register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_valid_r  <= 1'b0;
          s1_data_r   <= '0;
          s1_err_r    <= 1'b0;
          rsp_valid_r <= 1'b0;
          rsp_data_r  <= '0;
          rsp_err_r   <= 1'b0;
        end else begin
          if (out_free_s) begin
            rsp_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
              rsp_data_r <= s1_data_r;
              rsp_err_r  <= s1_err_r;
            end
          end
          if (out_free_s || !s1_valid_r) begin
            s1_valid_r <= rd_accept_s;
            if (rd_accept_s) begin
              s1_data_r <= rd_word_s;
              s1_err_r  <= !in_range_s;
            end
          end
        end
      end
    end else begin : g_lat1
      assign stall_s = !out_free_s;

      // Single-stage read pipeline: the captured word goes straight to the output.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rsp_valid_r <= 1'b0;
          rsp_data_r  <= '0;
          rsp_err_r   <= 1'b0;
        end else if (out_free_s) begin
          rsp_valid_r <= rd_accept_s;
          if (rd_accept_s) begin
            rsp_data_r <= rd_word_s;
            rsp_err_r  <= !in_range_s;
          end
        end
      end
    end
  endgenerate

  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_err   = rsp_err_r;
  assign busy      = (state_r == ST_CLEAR);

endmodule
